sdc_dma_seq: RTL and testbench

- Transfer sequencer for the SD DMA stream/Wishbone bridge, in the wb_clk domain.
- Accepts one multi-block transfer request (direction, start address, block count) and drives the bridge's tx_en/rx_en/base_addr.
- Counts Wishbone beats and SD block completions, and reports completion or a coded error to the SD controller register file.

---
 rtl/sdc_dma_seq.sv | 211 +++++++++++++++++++++
 tb/tb_sdc_dma_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sdc_dma_seq.sv
// Multi-block transfer sequencer for the SD DMA stream/Wishbone bridge (wb_clk domain).
// Loads the bridge address, gates tx_en/rx_en, tracks beats and block completions, reports done/error.
module sdc_dma_seq #(
  parameter int unsigned     WORDS_PER_BLK = 128,
  parameter int unsigned     CNT_W         = 16,
  parameter int unsigned     TO_W          = 24,
  parameter logic [TO_W-1:0] TIMEOUT       = 24'hFF_FFFF
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             start,
  input  logic             dir,
  input  logic [31:0]      start_addr,
  input  logic [CNT_W-1:0] blk_cnt,
  input  logic             abort,
  input  logic             dma_beat,
  input  logic             sd_blk_done,
  input  logic             sd_blk_err,
  output logic             tx_en,
  output logic             rx_en,
  output logic [31:0]      base_addr,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] blk_left
);

  localparam int unsigned WB_W   = $clog2(WORDS_PER_BLK);
  localparam int unsigned BEAT_W = CNT_W + WB_W;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SD      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [31:0]         base_q, base_d;
  logic [CNT_W-1:0]    blk_left_q, blk_left_d;
  logic [BEAT_W-1:0]   beat_left_q, beat_left_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                flush_q, flush_d;
  logic [1:0]          err_q, err_d;
  logic                tx_en_q, tx_en_d;
  logic                rx_en_q, rx_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                progress_s;
  logic                to_hit_s;
  logic                unused_addr_lsb;

  // The bridge works on word addresses; the byte offset is dropped on load.
  assign unused_addr_lsb = ^start_addr[1:0];

  // Next-state, counter and output-enable computation.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    base_d      = base_q;
    blk_left_d  = blk_left_q;
    beat_left_d = beat_left_q;
    to_d        = to_q;
    flush_d     = flush_q;
    err_d       = err_q;
    done_d      = 1'b0;
    progress_s  = dma_beat | sd_blk_done;
    to_hit_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = ERR_OK;
          if (blk_cnt != {CNT_W{1'b0}}) begin
            dir_d       = dir;
            base_d      = {start_addr[31:2], 2'b00};
            blk_left_d  = blk_cnt;
            beat_left_d = BEAT_W'(blk_cnt) * BEAT_W'(WORDS_PER_BLK);
            to_d        = {TO_W{1'b0}};
            state_d     = ST_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        flush_d = 1'b0;
        if (abort) begin
          err_d   = ERR_ABORT;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (dma_beat && (beat_left_q != {BEAT_W{1'b0}})) begin
          beat_left_d = beat_left_q - BEAT_W'(1);
        end else begin
          beat_left_d = beat_left_q;
        end
        if (sd_blk_done && (blk_left_q != {CNT_W{1'b0}})) begin
          blk_left_d = blk_left_q - CNT_W'(1);
        end else begin
          blk_left_d = blk_left_q;
        end
        // Any beat or block completion counts as forward progress.
        if (progress_s) begin
          to_d = {TO_W{1'b0}};
        end else begin
          to_d     = to_q + TO_W'(1);
          to_hit_s = ((to_q + TO_W'(1)) == TIMEOUT);
        end
        flush_d = 1'b0;
        if (abort) begin
          err_d   = ERR_ABORT;
          state_d = ST_FLUSH;
        end else if (sd_blk_err) begin
          err_d   = ERR_SD;
          state_d = ST_FLUSH;
        end else if (to_hit_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_FLUSH;
        end else if ((beat_left_d == {BEAT_W{1'b0}}) && (blk_left_d == {CNT_W{1'b0}})) begin
          err_d   = ERR_OK;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FLUSH: begin
        if (flush_q) begin
          flush_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          flush_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end else begin
      done_d = done_d;
    end

    // Enables exist only in RUN and only while beats remain, so no beat follows the last one.
    tx_en_d = (state_d == ST_RUN) && !dir_d && (beat_left_d != {BEAT_W{1'b0}});
    rx_en_d = (state_d == ST_RUN) &&  dir_d && (beat_left_d != {BEAT_W{1'b0}});
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_FLUSH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b0;
      base_q      <= 32'd0;
      blk_left_q  <= {CNT_W{1'b0}};
      beat_left_q <= {BEAT_W{1'b0}};
      to_q        <= {TO_W{1'b0}};
      flush_q     <= 1'b0;
      err_q       <= ERR_OK;
      tx_en_q     <= 1'b0;
      rx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      base_q      <= base_d;
      blk_left_q  <= blk_left_d;
      beat_left_q <= beat_left_d;
      to_q        <= to_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
      tx_en_q     <= tx_en_d;
      rx_en_q     <= rx_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_en     = tx_en_q;
  assign rx_en     = rx_en_q;
  assign base_addr = base_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_code  = err_q;
  assign blk_left  = blk_left_q;

endmodule

// File: tb/tb_sdc_dma_seq.sv
// Randomized scoreboard bench for sdc_dma_seq: a driver acts as bridge and SD data path,
// a negedge monitor checks each done pulse against expectations queued when the transfer started.
module tb_sdc_dma_seq;
  localparam int W     = 128;
  localparam int CNT_W = 16;

  logic             wb_clk = 1'b0;
  logic             wb_rst, start, dir, abort, dma_beat, sd_blk_done, sd_blk_err;
  logic [31:0]      start_addr;
  logic [CNT_W-1:0] blk_cnt;
  logic             tx_en, rx_en, busy, done;
  logic [31:0]      base_addr;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] blk_left;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int beats_total = 0;
  int beats_base = 0;
  logic [31:0] cur_base = 32'd0;

  typedef struct {
    int          err;
    int          blk_left;   // -1: not checked
    logic [31:0] base;
    int          beats;      // -1: not checked
  } exp_t;
  exp_t exp_q[$];

  sdc_dma_seq #(.WORDS_PER_BLK(W), .CNT_W(CNT_W), .TO_W(24), .TIMEOUT(24'd16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .dir(dir), .start_addr(start_addr),
    .blk_cnt(blk_cnt), .abort(abort), .dma_beat(dma_beat), .sd_blk_done(sd_blk_done),
    .sd_blk_err(sd_blk_err), .tx_en(tx_en), .rx_en(rx_en), .base_addr(base_addr),
    .busy(busy), .done(done), .err_code(err_code), .blk_left(blk_left)
  );

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) begin
    cyc <= cyc + 1;
    if (!wb_rst && dma_beat && (tx_en || rx_en)) beats_total <= beats_total + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each done pulse.
  always @(negedge wb_clk) begin
    exp_t e;
    chk("en_exclusive", {63'd0, tx_en & rx_en}, 64'd0);
    chk("en_needs_busy", {63'd0, (tx_en | rx_en) & ~busy}, 64'd0);
    if (done) begin
      chk("done_busy_low", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_err_code", {62'd0, err_code}, e.err);
        if (e.blk_left >= 0) chk("sb_blk_left", {48'd0, blk_left}, e.blk_left);
        chk("sb_base_addr", {32'd0, base_addr}, {32'd0, e.base});
        if (e.beats >= 0) chk("sb_beats", beats_total - beats_base, e.beats);
      end
    end
    if (!busy) beats_base = beats_total;
  end

  // mode: 0 normal, 1 sd error on block eb, 2 abort with final beat+block, 3 abort in LOAD, 4 timeout
  task automatic xfer(input logic d, input logic [31:0] a, input int cnt, input int mode, input int eb);
    exp_t e;
    int total, bd, kd, g, last, n;
    logic en, fin, pend;
    total = cnt * W;
    cur_base = {a[31:2], 2'b00};
    e.base = cur_base; e.err = 0; e.blk_left = 0; e.beats = total;
    case (mode)
      1: begin e.err = 1; e.blk_left = cnt - (eb - 1); e.beats = -1; end
      2: begin e.err = 3; e.blk_left = 0; end
      3: begin e.err = 3; e.blk_left = cnt; e.beats = 0; end
      4: begin e.err = 2; e.blk_left = cnt; e.beats = 0; end
      default: ;
    endcase
    exp_q.push_back(e);
    @(negedge wb_clk);
    start = 1'b1; dir = d; start_addr = a; blk_cnt = CNT_W'(cnt);
    @(negedge wb_clk);
    start = 1'b0; dir = $urandom; start_addr = $urandom; blk_cnt = CNT_W'($urandom);
    chk("load_busy", {63'd0, busy}, 64'd1);
    chk("load_en_low", {63'd0, tx_en | rx_en}, 64'd0);
    chk("load_base", {32'd0, base_addr}, {32'd0, cur_base});
    last = cyc;
    if (mode == 3) begin
      abort = 1'b1; last = cyc;
      @(negedge wb_clk);
      abort = 1'b0;
    end else if (mode == 4) begin
      @(negedge wb_clk);
      n = 0;
      while ((tx_en | rx_en) && n < 100) begin n++; @(negedge wb_clk); end
      chk("timeout_len", n, 16);
      last = cyc - 1;
    end else begin
      bd = 0; kd = 0; g = 0; fin = 1'b0;
      while (!fin && g < 4000) begin
        en = tx_en | rx_en;
        if (g == 1) begin
          chk("run_tx_en", {63'd0, tx_en}, {63'd0, !d});
          chk("run_rx_en", {63'd0, rx_en}, {63'd0, d});
        end
        if (g == 40) begin
          start = 1'b1; start_addr = $urandom; blk_cnt = CNT_W'($urandom_range(1, 9)); dir = ~d;
        end
        dma_beat = en && ($urandom_range(3) != 0);
        pend = (kd < cnt) && (bd >= (d ? (kd + 1) * W - 4 : (kd + 1) * W));
        if (mode == 2 && kd == cnt - 1) pend = 1'b0;
        if (mode == 2 && bd == total - 1 && kd < cnt - 1) dma_beat = 1'b0;
        if (mode == 2 && en && bd == total - 1 && kd == cnt - 1) begin
          dma_beat = 1'b1; sd_blk_done = 1'b1; abort = 1'b1; fin = 1'b1;
        end else if (pend && $urandom_range(2) != 0) begin
          if (mode == 1 && kd + 1 == eb) begin
            sd_blk_err = 1'b1; fin = 1'b1;
          end else begin
            sd_blk_done = 1'b1; kd++;
          end
        end
        if (dma_beat) bd++;
        if (mode == 0 && bd == total && kd == cnt) fin = 1'b1;
        if (fin) last = cyc;
        @(negedge wb_clk);
        g++;
        dma_beat = 1'b0; sd_blk_done = 1'b0; sd_blk_err = 1'b0; abort = 1'b0; start = 1'b0;
      end
      if (!fin) chk("xfer_stalled", 64'd0, 64'd1);
    end
    g = 0;
    while (!done && g < 30) begin @(negedge wb_clk); g++; end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("done_latency", cyc - last, 3);
    @(negedge wb_clk);
  endtask

  task automatic zero_start(input logic [31:0] a);
    exp_t e;
    e.err = 0; e.blk_left = -1; e.base = cur_base; e.beats = 0;
    exp_q.push_back(e);
    @(negedge wb_clk);
    start = 1'b1; blk_cnt = '0; dir = $urandom; start_addr = a;
    @(negedge wb_clk);
    start = 1'b0;
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_busy", {63'd0, busy}, 64'd0);
    chk("zero_en", {63'd0, tx_en | rx_en}, 64'd0);
    chk("zero_err", {62'd0, err_code}, 64'd0);
    @(negedge wb_clk);
    chk("zero_done_once", {63'd0, done}, 64'd0);
    chk("zero_busy_after", {63'd0, busy}, 64'd0);
  endtask

  task automatic rst_test();
    int seen;
    @(negedge wb_clk);
    start = 1'b1; dir = 1'b0; start_addr = 32'h0000_4000; blk_cnt = CNT_W'(3);
    @(negedge wb_clk);
    start = 1'b0;
    repeat (20) begin dma_beat = tx_en | rx_en; @(negedge wb_clk); end
    dma_beat = 1'b0; wb_rst = 1'b1;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_tx_en", {63'd0, tx_en}, 64'd0);
    chk("rst_base", {32'd0, base_addr}, 64'd0);
    chk("rst_blk_left", {48'd0, blk_left}, 64'd0);
    seen = 0;
    repeat (8) begin if (done) seen++; @(negedge wb_clk); end
    chk("rst_no_done", seen, 0);
    cur_base = 32'd0;
  endtask

  initial begin
    int m, c;
    wb_rst = 1'b1; start = 1'b0; dir = 1'b0; start_addr = 32'd0; blk_cnt = '0;
    abort = 1'b0; dma_beat = 1'b0; sd_blk_done = 1'b0; sd_blk_err = 1'b0;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("reset_state", {tx_en, rx_en, busy, done, err_code, blk_left, base_addr}, 64'd0);

    xfer(1'b0, 32'h0000_1003, 2, 0, 0);
    xfer(1'b1, $urandom, 1, 0, 0);
    xfer(1'b1, $urandom, 3, 1, 2);
    xfer(1'b0, $urandom, 2, 4, 0);
    xfer(1'b0, $urandom, 2, 2, 0);
    xfer(1'b1, $urandom, 2, 2, 0);
    xfer(1'b0, $urandom, 1, 3, 0);
    zero_start($urandom);
    rst_test();
    repeat (10) begin
      m = $urandom_range(0, 4);
      c = $urandom_range(1, 4);
      xfer(1'($urandom_range(0, 1)), $urandom, c, m, $urandom_range(1, c));
    end
    zero_start($urandom);
    repeat (5) @(negedge wb_clk);
    chk("scoreboard_drained", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
